// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, default
// latencies and the md-class decode the stall unit relies on.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    // Any op that must be held in D while the unit is occupied.
    function automatic logic is_md_class(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_MTLO));
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generation for mult/multu/div/divu, including the
// zero-divisor flag so the caller can suppress the HI/LO write.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_signed_mul;
    logic        is_signed_div;
    logic        is_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_signed_mul = (op == 3'(MD_MULT));
    assign is_signed_div = (op == 3'(MD_DIV));
    assign is_div        = (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));

    // Low 64 bits of a 64x64 product are the same for signed and unsigned,
    // so only the extension differs.
    assign ext_a = {{32{is_signed_mul & a[31]}}, a};
    assign ext_b = {{32{is_signed_mul & b[31]}}, b};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign neg_a = is_signed_div & a[31];
    assign neg_b = is_signed_div & b[31];
    assign mag_a = neg_a ? (32'd0 - a) : a;
    assign mag_b = neg_b ? (32'd0 - b) : b;
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign quo   = mag_a / div_b;
    assign rem   = mag_a % div_b;

    assign div_zero = is_div && (b == 32'd0);

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_lo = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
            res_hi = neg_a ? (32'd0 - rem) : rem;
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a shadow result
// that commits to HI/LO on the last busy cycle; single-cycle mthi/mtlo.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] shadow_hi_reg, shadow_hi_next;
    logic [31:0] shadow_lo_reg, shadow_lo_next;
    logic        commit_reg, commit_next;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div_zero;

    md_calc u_calc (
        .op       (md_op),
        .a        (A),
        .b        (B),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            shadow_hi_reg <= 32'd0;
            shadow_lo_reg <= 32'd0;
            commit_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            shadow_hi_reg <= shadow_hi_next;
            shadow_lo_reg <= shadow_lo_next;
            commit_reg    <= commit_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        shadow_hi_next = shadow_hi_reg;
        shadow_lo_next = shadow_lo_reg;
        commit_next    = commit_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            shadow_hi_next = calc_hi;
                            shadow_lo_next = calc_lo;
                            commit_next    = 1'b1;
                            cnt_next       = 4'(MULT_CYCLES);
                            state_next     = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            shadow_hi_next = calc_hi;
                            shadow_lo_next = calc_lo;
                            commit_next    = ~calc_div_zero;
                            cnt_next       = 4'(DIV_CYCLES);
                            state_next     = ST_RUN;
                        end
                        MD_MTHI: hi_next = A;
                        MD_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Any start seen here is dropped: the stall unit never issues one.
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_IDLE;
                    if (commit_reg) begin
                        hi_next = shadow_hi_reg;
                        lo_next = shadow_lo_reg;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops
// checked against a transaction-level arithmetic model of HI/LO.
module tb_md_unit;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one op on HI/LO and how many busy cycles it takes.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int n);
        longint sa, sb, q, r;
        logic [63:0] p;
        n = 0;
        case (op)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                hi = p[63:32]; lo = p[31:0]; n = N_MULT;
            end
            3'd2: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32]; lo = p[31:0]; n = N_MULT;
            end
            3'd3: begin
                n = N_DIV;
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
            3'd4: begin
                n = N_DIV;
                if (b != 32'd0) begin
                    lo = a / b; hi = a % b;
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = m_hi;
        old_lo = m_lo;
        model(op, a, b, m_hi, m_lo, n);
        start = 1'b1; md_op = op; A = a; B = b;
        step();
        start = 1'b0; A = $urandom; B = $urandom; md_op = 3'($urandom);
        for (int i = 1; i <= n; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            if (i == n) begin
                check("hi_hold", HI, old_hi);
                check("lo_hold", LO, old_lo);
            end
            step();
        end
        check("busy_done", {31'd0, busy}, 32'd0);
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        $display("op=%0d a=%h b=%h cycles=%0d -> HI=%h LO=%h", op, a, b, n, HI, LO);
    endtask

    initial begin
        logic [31:0] exp_hi, exp_lo;
        int n;

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();

        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        run_op(3'd4, 32'd7, 32'd2);
        run_op(3'd5, 32'h11, 32'd0);
        run_op(3'd6, 32'h22, 32'd0);
        run_op(3'd3, 32'd5, 32'd0);
        run_op(3'd4, 32'd5, 32'd0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd5, 32'hDEADBEEF, 32'd0);
        run_op(3'd6, 32'hCAFEF00D, 32'd0);
        run_op(3'd0, 32'h12345678, 32'd1);
        run_op(3'd7, 32'h12345678, 32'd1);

        // A MULT issued while a DIV is running must be dropped.
        exp_hi = m_hi; exp_lo = m_lo;
        model(3'd3, 32'hFFFFFF9C, 32'd7, exp_hi, exp_lo, n);
        start = 1'b1; md_op = 3'd3; A = 32'hFFFFFF9C; B = 32'd7;
        step();
        start = 1'b0;
        check("ovl_busy_t1", {31'd0, busy}, 32'd1);
        step();
        start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
        step();
        start = 1'b0;
        for (int i = 3; i <= N_DIV; i++) begin
            check("ovl_busy", {31'd0, busy}, 32'd1);
            step();
        end
        check("ovl_busy_end", {31'd0, busy}, 32'd0);
        check("ovl_hi", HI, exp_hi);
        check("ovl_lo", LO, exp_lo);
        m_hi = exp_hi; m_lo = exp_lo;
        for (int i = 0; i < 6; i++) begin
            check("ovl_idle", {31'd0, busy}, 32'd0);
            check("ovl_hi_keep", HI, m_hi);
            step();
        end
        $display("overlap div -> HI=%h LO=%h", HI, LO);

        // Reset in the middle of a MULT aborts it with no partial write.
        run_op(3'd2, 32'h00010001, 32'h00010001);
        start = 1'b1; md_op = 3'd1; A = 32'h7FFFFFFF; B = 32'h7FFFFFFF;
        step();
        start = 1'b0;
        step(); step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        step(); step();
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            check("post_rst_hi", HI, 32'd0);
            check("post_rst_lo", LO, 32'd0);
            step();
        end
        $display("reset mid-mult -> HI=%h LO=%h busy=%0d", HI, LO, busy);

        for (int k = 0; k < 60; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_op(op, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
